nfp_match_extractor: RTL and testbench

- Downstream of the non-fast-pattern shift-or stage. Consumes its 128-bit per-beat state vector: 16 bytes × 8 buckets, and a 0 bit means a bucket match ending at that byte.
- Buffers beats that carry matches and serializes them into one event per cycle, {bucket, packet byte offset}, on a valid/ready stream for the rule-check stage.
- Emits one end-of-packet event per packet carrying the packet's match count.

---
 rtl/nfp_match_extractor.sv | 245 ++++++++++++++++++++++++
 tb/tb_nfp_match_extractor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/nfp_match_extractor.sv
// Serializes shift-or match vectors into {bucket, offset} events plus one end event per packet.
// Optional NFP_BUCKET_MASK_EN adds cfg_bucket_mask to suppress selected buckets.
// Output stream: an event is transferred on a cycle with out_valid & out_ready; while
// out_valid is high and out_ready low, every out_* field holds and out_valid stays high.
module nfp_match_extractor #(
  parameter int FIFO_DEPTH = 8,
  parameter int OFFSET_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [127:0]                  in_data,
`ifdef NFP_BUCKET_MASK_EN
  input  logic [7:0]                    cfg_bucket_mask,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_kind,
  output logic [2:0]                    out_bucket,
  output logic [OFFSET_W-1:0]           out_offset,
  output logic [15:0]                   out_count,
  output logic                          out_trunc,
  output logic                          overflow_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = OFFSET_W - 4;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_END} state_t;

  logic [127:0]  mem_m_q     [FIFO_DEPTH];
  logic [IW-1:0] mem_idx_q   [FIFO_DEPTH];
  logic          mem_eop_q   [FIFO_DEPTH];
  logic          mem_trunc_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic [IW-1:0] bidx_q, bidx_d, cur_idx;
  logic          trunc_q, trunc_d, pkt_has_q, pkt_has_d, lost_end_q, lost_end_d;
  logic          ovf_q, ovf_d;
  logic [127:0]  m_in;
  logic          need_store, full, push, lost, trunc_base, has_base, ent_trunc, patch_tail;
  logic          pop;

  state_t        state_q, state_d;
  logic [127:0]  work_q, work_d, work_nxt;
  logic [15:0]   match_cnt_q, match_cnt_d, match_cnt_inc;
  logic          ov_q, ov_d, kind_q, kind_d, otrunc_q, otrunc_d;
  logic [2:0]    bucket_q, bucket_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [15:0]   ocount_q, ocount_d;
  logic [127:0]  head_m;
  logic [IW-1:0] head_idx;
  logic          head_eop, head_trunc;
  logic [6:0]    k_head, k_cur, k_nxt;

  function automatic logic [6:0] lsb_idx(input logic [127:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 127; i >= 0; i--) begin
      if (v[i]) r = 7'(i);
    end
    return r;
  endfunction

  // Input side: beat indexing, storage decision, overflow and truncation tracking.
  always_comb begin
`ifdef NFP_BUCKET_MASK_EN
    m_in = ~in_data & ~{16{cfg_bucket_mask}};
`else
    m_in = ~in_data;
`endif
    cur_idx    = in_sop ? '0 : bidx_q + IW'(1);
    need_store = in_valid && ((|m_in) || in_eop);
    full       = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
    push       = need_store && (!full || pop);
    lost       = need_store && full && !pop;
    trunc_base = in_sop ? 1'b0 : trunc_q;
    has_base   = in_sop ? 1'b0 : pkt_has_q;
    ent_trunc  = trunc_base | lost_end_q;
    tail_ptr   = wr_ptr_q - AW'(1);
    // A lost end marker is folded onto the packet's newest buffered entry when one exists.
    patch_tail = lost && in_eop && has_base;

    bidx_d     = in_valid ? cur_idx : bidx_q;
    trunc_d    = in_valid ? (trunc_base | lost) : trunc_q;
    pkt_has_d  = in_valid ? (has_base | push) : pkt_has_q;
    lost_end_d = lost_end_q;
    if (push) lost_end_d = 1'b0;
    else if (lost && in_eop && !has_base) lost_end_d = 1'b1;
    ovf_d      = ovf_q | lost;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_m_q[wr_ptr_q]     <= m_in;
      mem_idx_q[wr_ptr_q]   <= cur_idx;
      mem_eop_q[wr_ptr_q]   <= in_eop;
      mem_trunc_q[wr_ptr_q] <= ent_trunc;
    end else if (patch_tail) begin
      mem_eop_q[tail_ptr]   <= 1'b1;
      mem_trunc_q[tail_ptr] <= 1'b1;
    end
  end

  // Output side: event fields are computed one step ahead so they leave straight from flops.
  always_comb begin
    head_m        = mem_m_q[rd_ptr_q];
    head_idx      = mem_idx_q[rd_ptr_q];
    head_eop      = mem_eop_q[rd_ptr_q];
    head_trunc    = mem_trunc_q[rd_ptr_q];
    k_head        = lsb_idx(head_m);
    k_cur         = {offset_q[3:0], bucket_q};
    work_nxt      = work_q;
    work_nxt[k_cur] = 1'b0;
    k_nxt         = lsb_idx(work_nxt);
    match_cnt_inc = (match_cnt_q == 16'hFFFF) ? match_cnt_q : match_cnt_q + 16'd1;

    state_d     = state_q;
    work_d      = work_q;
    match_cnt_d = match_cnt_q;
    ov_d        = ov_q;
    kind_d      = kind_q;
    bucket_d    = bucket_q;
    offset_d    = offset_q;
    ocount_d    = ocount_q;
    otrunc_d    = otrunc_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_cnt_q != '0) begin
          ov_d = 1'b1;
          if (|head_m) begin
            work_d   = head_m;
            kind_d   = 1'b0;
            bucket_d = k_head[2:0];
            offset_d = {head_idx, k_head[6:3]};
            ocount_d = '0;
            otrunc_d = 1'b0;
            state_d  = S_SCAN;
          end else begin
            kind_d   = 1'b1;
            bucket_d = '0;
            offset_d = '0;
            ocount_d = match_cnt_q;
            otrunc_d = head_trunc;
            state_d  = S_END;
          end
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          match_cnt_d = match_cnt_inc;
          work_d      = work_nxt;
          if (|work_nxt) begin
            bucket_d = k_nxt[2:0];
            offset_d = {head_idx, k_nxt[6:3]};
          end else if (head_eop) begin
            kind_d   = 1'b1;
            bucket_d = '0;
            offset_d = '0;
            ocount_d = match_cnt_inc;
            otrunc_d = head_trunc;
            state_d  = S_END;
          end else begin
            pop      = 1'b1;
            ov_d     = 1'b0;
            bucket_d = '0;
            offset_d = '0;
            state_d  = S_IDLE;
          end
        end
      end
      S_END: begin
        if (out_ready) begin
          pop         = 1'b1;
          match_cnt_d = '0;
          ov_d        = 1'b0;
          kind_d      = 1'b0;
          ocount_d    = '0;
          otrunc_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      bidx_q      <= '0;
      trunc_q     <= 1'b0;
      pkt_has_q   <= 1'b0;
      lost_end_q  <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      work_q      <= '0;
      match_cnt_q <= '0;
      ov_q        <= 1'b0;
      kind_q      <= 1'b0;
      bucket_q    <= '0;
      offset_q    <= '0;
      ocount_q    <= '0;
      otrunc_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      bidx_q      <= bidx_d;
      trunc_q     <= trunc_d;
      pkt_has_q   <= pkt_has_d;
      lost_end_q  <= lost_end_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      work_q      <= work_d;
      match_cnt_q <= match_cnt_d;
      ov_q        <= ov_d;
      kind_q      <= kind_d;
      bucket_q    <= bucket_d;
      offset_q    <= offset_d;
      ocount_q    <= ocount_d;
      otrunc_q    <= otrunc_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_kind     = kind_q;
  assign out_bucket   = bucket_q;
  assign out_offset   = offset_q;
  assign out_count    = ocount_q;
  assign out_trunc    = otrunc_q;
  assign overflow_err = ovf_q;
  assign fifo_level   = fifo_cnt_q;

endmodule

// File: tb/tb_nfp_match_extractor.sv
// Directed bench for nfp_match_extractor: hand-computed events checked with immediate assertions.
module tb_nfp_match_extractor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_sop, in_eop;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_kind, out_trunc, overflow_err;
  logic [2:0]   out_bucket;
  logic [15:0]  out_offset, out_count;
  logic [3:0]   fifo_level;
`ifdef NFP_BUCKET_MASK_EN
  logic [7:0]   cfg_bucket_mask;
`endif

  int n_vec = 0;
  int n_err = 0;
  int w;

  localparam logic [127:0] ONES = '1;

  always #5 clk = ~clk;

  nfp_match_extractor #(.FIFO_DEPTH(8), .OFFSET_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
`ifdef NFP_BUCKET_MASK_EN
    .cfg_bucket_mask(cfg_bucket_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_bucket(out_bucket), .out_offset(out_offset), .out_count(out_count),
    .out_trunc(out_trunc), .overflow_err(overflow_err), .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [127:0] data);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = ONES;
  endtask

  // Waits (bounded) for out_valid at falling edges, checks the event, then lets one rising edge pass.
  task automatic expect_ev(input string tag, input logic kind, input logic [2:0] b,
                           input logic [15:0] off, input logic [15:0] cnt, input logic t,
                           output int waited);
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    chk(tag, {26'd0, out_valid, out_kind, out_bucket, out_offset, out_count, out_trunc},
             {26'd0, 1'b1, kind, b, off, cnt, t});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = ONES;
    out_ready = 1'b1;
`ifdef NFP_BUCKET_MASK_EN
    cfg_bucket_mask = 8'h00;
`endif
    #12;
    chk("reset_outputs", {21'd0, out_valid, out_kind, out_bucket, out_offset, out_count,
                          out_trunc, overflow_err, fifo_level}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // One-beat packet, bit 29 = byte 3 bucket 5.
    beat(1'b1, 1'b1, ~(128'h1 << 29));
    expect_ev("p1_match", 1'b0, 3'd5, 16'd3, 16'd0, 1'b0, w);
    chk("p1_latency", 64'(w), 64'd1);
    expect_ev("p1_end", 1'b1, 3'd0, 16'd0, 16'd1, 1'b0, w);

    // Three-beat packet, only beat 2 has matches at bits 0 and 127.
    beat(1'b1, 1'b0, ONES);
    chk("p2_level_b0", 64'(fifo_level), 64'd0);
    beat(1'b0, 1'b0, ONES);
    chk("p2_level_b1", 64'(fifo_level), 64'd0);
    beat(1'b0, 1'b1, ~((128'h1 << 127) | 128'h1));
    chk("p2_level_b2", 64'(fifo_level), 64'd1);
    expect_ev("p2_match0", 1'b0, 3'd0, 16'd32, 16'd0, 1'b0, w);
    expect_ev("p2_match1", 1'b0, 3'd7, 16'd47, 16'd0, 1'b0, w);
    expect_ev("p2_end", 1'b1, 3'd0, 16'd0, 16'd2, 1'b0, w);

    // Packet whose only stored entry is the eop-only beat.
    beat(1'b1, 1'b0, ONES);
    beat(1'b0, 1'b1, ONES);
    expect_ev("eop_only_end", 1'b1, 3'd0, 16'd0, 16'd0, 1'b0, w);

    // Stall: byte 2 buckets 0 and 4, out_ready low for six cycles.
    out_ready = 1'b0;
    beat(1'b1, 1'b1, ~((128'h1 << 16) | (128'h1 << 20)));
    expect_ev("stall_first", 1'b0, 3'd0, 16'd2, 16'd0, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      expect_ev("stall_hold", 1'b0, 3'd0, 16'd2, 16'd0, 1'b0, w);
      chk("stall_no_gap", 64'(w), 64'd0);
    end
    out_ready = 1'b1;
    expect_ev("stall_take0", 1'b0, 3'd0, 16'd2, 16'd0, 1'b0, w);
    expect_ev("stall_take1", 1'b0, 3'd4, 16'd2, 16'd0, 1'b0, w);
    chk("stall_take1_gap", 64'(w), 64'd0);
    expect_ev("stall_end", 1'b1, 3'd0, 16'd0, 16'd2, 1'b0, w);

    // Overflow: 10 all-match beats into an 8-entry buffer, eop on the lost beat 9.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 128'd0);
    @(negedge clk);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_err", 64'(overflow_err), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      for (int k = 0; k < 128; k++) begin
        expect_ev("ovf_match", 1'b0, 3'(k % 8), 16'(e * 16 + k / 8), 16'd0, 1'b0, w);
      end
    end
    expect_ev("ovf_end", 1'b1, 3'd0, 16'd0, 16'd1024, 1'b1, w);
    @(negedge clk);
    chk("ovf_err_sticky", 64'(overflow_err), 64'd1);
    chk("ovf_drained", 64'({out_valid, fifo_level}), 64'd0);

    // Asynchronous reset in the middle of a scan.
    beat(1'b1, 1'b1, 128'd0);
    expect_ev("rst_pre0", 1'b0, 3'd0, 16'd0, 16'd0, 1'b0, w);
    expect_ev("rst_pre1", 1'b0, 3'd1, 16'd0, 16'd0, 1'b0, w);
    expect_ev("rst_pre2", 1'b0, 3'd2, 16'd0, 16'd0, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {21'd0, out_valid, out_kind, out_bucket, out_offset, out_count,
                      out_trunc, overflow_err, fifo_level}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    beat(1'b1, 1'b1, ~128'h1);
    expect_ev("rst_post_match", 1'b0, 3'd0, 16'd0, 16'd0, 1'b0, w);
    expect_ev("rst_post_end", 1'b1, 3'd0, 16'd0, 16'd1, 1'b0, w);

`ifdef NFP_BUCKET_MASK_EN
    cfg_bucket_mask = 8'hFE;
    beat(1'b1, 1'b1, 128'd0);
    for (int b = 0; b < 16; b++) begin
      expect_ev("mask_match", 1'b0, 3'd0, 16'(b), 16'd0, 1'b0, w);
    end
    expect_ev("mask_end", 1'b1, 3'd0, 16'd0, 16'd16, 1'b0, w);
    cfg_bucket_mask = 8'h00;
`endif

    @(negedge clk);
    chk("final_idle", 64'({out_valid, fifo_level}), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
